framebuffer_dbuf: RTL

Double-buffered single-clock pixel framebuffer, the parametrised successor to the single-page dual-port framebuffer.
- Memory holds two pages of 2**ADDR_WIDTH pixels.
- Display reads always come from the front page; pixel writes always go to the back page.
- A swap request is deferred to the next frame_sync pulse, giving tear-free page flips.
- A built-in fill engine clears the back page to a constant colour.
- Sits between the pixel generator/DMA writer and the video timing/scan-out logic.

---
 rtl/fb_pkg.sv | 21 ++
 rtl/fb_fill_engine.sv | 70 +++++++
 rtl/framebuffer_dbuf.sv | 134 +++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// Shared definitions for the double-buffered framebuffer: default geometry,
// fill FSM state encoding and page-select helpers.
package fb_pkg;

  localparam int FB_ADDR_WIDTH = 16;
  localparam int FB_DATA_WIDTH = 24;

  // Page shown after reset; the back page is always its complement.
  localparam logic FRONT_PAGE_RST = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } fill_state_e;

  function automatic logic back_page(input logic front_sel);
    return ~front_sel;
  endfunction

endpackage

// File: rtl/fb_fill_engine.sv
// Back-page clear engine: sweeps every pixel address once with a latched
// colour, then emits a single-cycle done pulse.
module fb_fill_engine
  import fb_pkg::*;
#(
  parameter int ADDR_WIDTH = FB_ADDR_WIDTH,
  parameter int DATA_WIDTH = FB_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fill_start,
  input  logic [DATA_WIDTH-1:0] fill_value,
  output logic                  fill_busy,
  output logic                  fill_done,
  output logic                  fill_we,
  output logic [ADDR_WIDTH-1:0] fill_addr,
  output logic [DATA_WIDTH-1:0] fill_data
);

  fill_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] value_q, value_d;
  logic                  last_pixel;

  assign last_pixel = (cnt_q == {ADDR_WIDTH{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      value_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      value_q <= value_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (fill_start) state_d = ST_FILL;
      ST_FILL: if (last_pixel) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Colour is captured only on an accepted start; starts while busy/done are ignored.
  always_comb begin
    cnt_d   = cnt_q;
    value_d = value_q;
    if (state_q == ST_IDLE && fill_start) begin
      cnt_d   = '0;
      value_d = fill_value;
    end else if (state_q == ST_FILL) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    fill_busy = (state_q == ST_FILL);
    fill_done = (state_q == ST_DONE);
    fill_we   = (state_q == ST_FILL);
  end

  assign fill_addr = cnt_q;
  assign fill_data = value_q;

endmodule

// File: rtl/framebuffer_dbuf.sv
// Double-buffered pixel framebuffer with frame-synchronised page flips and a
// back-page fill engine. Define FRAMEBUFFER_DBUF_OUTREG_EN for a 2-cycle read.
module framebuffer_dbuf
  import fb_pkg::*;
#(
  parameter int ADDR_WIDTH = FB_ADDR_WIDTH,
  parameter int DATA_WIDTH = FB_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  swap_req,
  input  logic                  frame_sync,
  output logic                  swap_pending,
  output logic                  front_sel,
  input  logic                  fill_start,
  input  logic [DATA_WIDTH-1:0] fill_value,
  output logic                  fill_busy,
  output logic                  fill_done
);

  localparam int MEM_DEPTH = 2 ** (ADDR_WIDTH + 1);

  logic [DATA_WIDTH-1:0] mem [0:MEM_DEPTH-1];

  logic                  front_sel_q, front_sel_d;
  logic                  swap_pending_q, swap_pending_d;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;

  logic                  fill_we;
  logic [ADDR_WIDTH-1:0] fill_addr;
  logic [DATA_WIDTH-1:0] fill_data;

  logic                  mem_we;
  logic [ADDR_WIDTH:0]   mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  fb_fill_engine #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fill (
    .clk        (clk),
    .rst        (rst),
    .fill_start (fill_start),
    .fill_value (fill_value),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done),
    .fill_we    (fill_we),
    .fill_addr  (fill_addr),
    .fill_data  (fill_data)
  );

  // Fill engine owns the write port while busy; user writes are dropped then.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = {back_page(front_sel_q), wr_addr};
    mem_wdata = wr_data;
    if (!rst) begin
      if (fill_we) begin
        mem_we    = 1'b1;
        mem_waddr = {back_page(front_sel_q), fill_addr};
        mem_wdata = fill_data;
      end else if (wr_en) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) rd_data_q <= mem[{front_sel_q, rd_addr}];
    end
  end

  // A flip waits for frame_sync and never happens while the back page is being filled.
  always_comb begin
    front_sel_d    = front_sel_q;
    swap_pending_d = swap_pending_q | swap_req;
    if (frame_sync && (swap_pending_q || swap_req) && !fill_busy) begin
      front_sel_d    = ~front_sel_q;
      swap_pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      front_sel_q    <= FRONT_PAGE_RST;
      swap_pending_q <= 1'b0;
    end else begin
      front_sel_q    <= front_sel_d;
      swap_pending_q <= swap_pending_d;
    end
  end

  assign front_sel    = front_sel_q;
  assign swap_pending = swap_pending_q;

`ifdef FRAMEBUFFER_DBUF_OUTREG_EN
  logic [DATA_WIDTH-1:0] rd_data2_q;
  logic                  rd_valid2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data2_q  <= '0;
      rd_valid2_q <= 1'b0;
    end else begin
      rd_data2_q  <= rd_data_q;
      rd_valid2_q <= rd_valid_q;
    end
  end

  assign rd_data  = rd_data2_q;
  assign rd_valid = rd_valid2_q;
`else
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`endif

endmodule
